// File: rtl/hs_perf_monitor.sv
// hs_perf_monitor: counts accepted beats and stall cycles on the HOG core input
// and the bus-switch output handshakes, detects a stuck input handshake, and
// presents snapshot-consistent counter words plus a status word to the HPS.
//
// Ports:
//   clk, rst                     clock, synchronous active-low reset
//   hog_input_valid/ready        HOG core input handshake (observed only)
//   switch_out_valid/ready       bus-switch output handshake (observed only)
//   ctrl_pio[31:0]               bit0 snap_req (rise), bit1 clear_req (rise), bit2 enable
//   in_beats_pio, in_stall_pio   snapshot of input beat / stall counters
//   out_beats_pio, out_stall_pio snapshot of output beat / stall counters
//   status_pio[31:0]             bit0 snap_valid, bit1 deadlock, bit2 saturated, [5:4] state
//   deadlock_led                 copy of the deadlock flag
module hs_perf_monitor #(
  parameter int unsigned CNT_WIDTH   = 32,
  parameter int unsigned STALL_LIMIT = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hog_input_valid,
  input  logic        hog_input_ready,
  input  logic        switch_out_valid,
  input  logic        switch_out_ready,
  input  logic [31:0] ctrl_pio,
  output logic [31:0] in_beats_pio,
  output logic [31:0] in_stall_pio,
  output logic [31:0] out_beats_pio,
  output logic [31:0] out_stall_pio,
  output logic [31:0] status_pio,
  output logic        deadlock_led
);

  localparam int unsigned NUM_CNT = 4;
  localparam int unsigned SR_W    = $clog2(STALL_LIMIT + 1);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [SR_W-1:0]      STALL_AT  = SR_W'(STALL_LIMIT - 1);
  localparam logic [SR_W-1:0]      STALL_SAT = SR_W'(STALL_LIMIT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    STALLED = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [1:0]                          ctrl_q;
  logic [NUM_CNT-1:0][CNT_WIDTH-1:0]   live_cnt;
  logic [NUM_CNT-1:0][CNT_WIDTH-1:0]   snap_cnt;
  logic [SR_W-1:0]                     stall_run;
  logic                                snap_valid;
  logic                                deadlock;
  logic                                saturated;

  logic                                snap_rise_c;
  logic                                clear_rise_c;
  logic                                enable_c;
  logic                                counting_c;
  logic                                enter_stalled_c;
  logic                                sat_hit_c;
  logic [NUM_CNT-1:0]                  event_c;
  logic                                unused_ctrl;

  // Only the low three control bits carry meaning.
  assign unused_ctrl = ^ctrl_pio[31:3];

  assign snap_rise_c  = ctrl_pio[0] & ~ctrl_q[0];
  assign clear_rise_c = ctrl_pio[1] & ~ctrl_q[1];
  assign enable_c     = ctrl_pio[2];
  assign counting_c   = (state != IDLE);

  // Event order matches the counter order: in_beat, in_stall, out_beat, out_stall.
  assign event_c = {switch_out_valid & ~switch_out_ready,
                    switch_out_valid &  switch_out_ready,
                    hog_input_valid  & ~hog_input_ready,
                    hog_input_valid  &  hog_input_ready};

  // An increment attempted on a counter already at all-ones flags saturation.
  always_comb begin
    sat_hit_c = 1'b0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (counting_c && event_c[i] && (live_cnt[i] == CNT_MAX)) sat_hit_c = 1'b1;
    end
  end

  // Next-state logic; a clear blocks entry to STALLED and releases STALLED to RUN.
  always_comb begin
    state_nxt       = state;
    enter_stalled_c = 1'b0;
    if (!enable_c) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = RUN;
        RUN: begin
          if (event_c[1] && !clear_rise_c && (stall_run == STALL_AT)) begin
            state_nxt       = STALLED;
            enter_stalled_c = 1'b1;
          end
        end
        STALLED: begin
          if (!event_c[1] || clear_rise_c) state_nxt = RUN;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State register and control edge history; ctrl_q tracks ctrl_pio through reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      ctrl_q <= ctrl_pio[1:0];
    end else begin
      state  <= state_nxt;
      ctrl_q <= ctrl_pio[1:0];
    end
  end

  // Consecutive input-stall run length, saturating at the limit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_run <= '0;
    end else if (!counting_c || clear_rise_c || !event_c[1]) begin
      stall_run <= '0;
    end else if (stall_run != STALL_SAT) begin
      stall_run <= stall_run + SR_W'(1);
    end
  end

  // Live counters: clear wins over a same-cycle increment; all-ones is sticky.
  always_ff @(posedge clk) begin
    if (!rst) begin
      live_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        if (clear_rise_c) begin
          live_cnt[i] <= '0;
        end else if (counting_c && event_c[i] && (live_cnt[i] != CNT_MAX)) begin
          live_cnt[i] <= live_cnt[i] + CNT_WIDTH'(1);
        end
      end
    end
  end

  // Snapshot captures pre-increment, pre-clear live values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      snap_cnt <= '0;
    end else if (snap_rise_c) begin
      snap_cnt <= live_cnt;
    end
  end

  // Sticky flags; a same-cycle snapshot keeps snap_valid set across a clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      snap_valid <= 1'b0;
      deadlock   <= 1'b0;
      saturated  <= 1'b0;
    end else begin
      if (snap_rise_c)       snap_valid <= 1'b1;
      else if (clear_rise_c) snap_valid <= 1'b0;

      if (clear_rise_c)         deadlock <= 1'b0;
      else if (enter_stalled_c) deadlock <= 1'b1;

      if (clear_rise_c)   saturated <= 1'b0;
      else if (sat_hit_c) saturated <= 1'b1;
    end
  end

  assign in_beats_pio  = 32'(snap_cnt[0]);
  assign in_stall_pio  = 32'(snap_cnt[1]);
  assign out_beats_pio = 32'(snap_cnt[2]);
  assign out_stall_pio = 32'(snap_cnt[3]);
  assign status_pio    = {26'd0, state, 1'b0, saturated, deadlock, snap_valid};
  assign deadlock_led  = deadlock;

endmodule

// File: tb/tb_hs_perf_monitor.sv
module tb_hs_perf_monitor;

  localparam int unsigned CW   = 4;
  localparam int unsigned SL   = 16;
  localparam int          CMAX = (1 << CW) - 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        hiv, hir, sov, sor;
  logic [31:0] ctrl;
  logic [31:0] in_beats_pio, in_stall_pio, out_beats_pio, out_stall_pio, status_pio;
  logic        deadlock_led;

  int checks = 0;
  int errors = 0;

  // Reference model: integer counts, state as 0/1/2.
  int   m_state, m_run, m_sv, m_dl, m_sat;
  int   m_cnt [4];
  int   m_snap[4];
  logic [1:0] m_prev;

  always #5 clk = ~clk;

  hs_perf_monitor #(.CNT_WIDTH(CW), .STALL_LIMIT(SL)) dut (
    .clk              (clk),
    .rst              (rst),
    .hog_input_valid  (hiv),
    .hog_input_ready  (hir),
    .switch_out_valid (sov),
    .switch_out_ready (sor),
    .ctrl_pio         (ctrl),
    .in_beats_pio     (in_beats_pio),
    .in_stall_pio     (in_stall_pio),
    .out_beats_pio    (out_beats_pio),
    .out_stall_pio    (out_stall_pio),
    .status_pio       (status_pio),
    .deadlock_led     (deadlock_led)
  );

  function automatic logic [31:0] m_status();
    return 32'((m_state * 16) + (m_sat * 4) + (m_dl * 2) + m_sv);
  endfunction

  // Advance the model over the current cycle's inputs, then cross the clock edge.
  task automatic tick();
    bit snap, clr, en, stall, was_counting, dl_now;
    int ev[4];
    int nxt;
    if (!rst) begin
      m_state = 0; m_run = 0; m_sv = 0; m_dl = 0; m_sat = 0;
      for (int i = 0; i < 4; i++) begin m_cnt[i] = 0; m_snap[i] = 0; end
    end else begin
      snap  = ctrl[0] && !m_prev[0];
      clr   = ctrl[1] && !m_prev[1];
      en    = ctrl[2];
      stall = hiv && !hir;
      ev[0] = int'(hiv && hir);
      ev[1] = int'(stall);
      ev[2] = int'(sov && sor);
      ev[3] = int'(sov && !sor);
      was_counting = (m_state != 0);
      if (snap) for (int i = 0; i < 4; i++) m_snap[i] = m_cnt[i];
      if (clr) m_sat = 0;
      for (int i = 0; i < 4; i++) begin
        if (clr) m_cnt[i] = 0;
        else if (was_counting && ev[i] == 1) begin
          if (m_cnt[i] >= CMAX) m_sat = 1;
          else m_cnt[i] = m_cnt[i] + 1;
        end
      end
      dl_now = en && (m_state == 1) && stall && !clr && (m_run == SL - 1);
      if (!en) nxt = 0;
      else if (m_state == 0) nxt = 1;
      else if (dl_now) nxt = 2;
      else if (m_state == 2 && stall && !clr) nxt = 2;
      else nxt = 1;
      if (was_counting && stall && !clr) m_run = (m_run + 1 > SL) ? SL : m_run + 1;
      else m_run = 0;
      if (snap) m_sv = 1; else if (clr) m_sv = 0;
      if (clr) m_dl = 0; else if (dl_now) m_dl = 1;
      m_state = nxt;
    end
    m_prev = ctrl[1:0];
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; ctrl = 32'h0; hiv = 0; hir = 0; sov = 0; sor = 0;
    tick(); tick();
    checks++;
    if ({in_beats_pio, in_stall_pio, out_beats_pio, out_stall_pio} !== 128'd0) begin
      errors++; $display("FAIL reset_counters: got %h required 0", {in_beats_pio, in_stall_pio, out_beats_pio, out_stall_pio});
    end
    checks++;
    if (status_pio !== 32'h0) begin
      errors++; $display("FAIL reset_status: got %h required 00000000", status_pio);
    end
    checks++;
    if (deadlock_led !== 1'b0) begin
      errors++; $display("FAIL reset_led: got %b required 0", deadlock_led);
    end
    rst = 1'b1;
  endtask

  task automatic test_counting();
    ctrl = 32'h4; tick();
    checks++;
    if (status_pio !== 32'h10) begin
      errors++; $display("FAIL count_enter_run: got %h required 00000010", status_pio);
    end
    hiv = 1; hir = 1; repeat (10) tick();
    hir = 0;          repeat (4)  tick();
    hiv = 0; sov = 1; sor = 1; repeat (7) tick();
    sor = 0;          repeat (3)  tick();
    sov = 0; ctrl = 32'h5; tick();
    checks++;
    if ({in_beats_pio, in_stall_pio, out_beats_pio, out_stall_pio} !== {32'd10, 32'd4, 32'd7, 32'd3}) begin
      errors++; $display("FAIL count_snapshot: got %0d/%0d/%0d/%0d required 10/4/7/3",
                         in_beats_pio, in_stall_pio, out_beats_pio, out_stall_pio);
    end
    checks++;
    if (status_pio !== 32'h11) begin
      errors++; $display("FAIL count_status: got %h required 00000011", status_pio);
    end
    ctrl = 32'h4; tick();
  endtask

  task automatic test_idle_hold();
    ctrl = 32'h6; tick();
    ctrl = 32'h0; tick();
    hiv = 1; hir = 1; sov = 1; sor = 1; repeat (20) tick();
    hiv = 0; hir = 0; sov = 0; sor = 0;
    ctrl = 32'h1; tick();
    checks++;
    if ({in_beats_pio, in_stall_pio, out_beats_pio, out_stall_pio} !== 128'd0) begin
      errors++; $display("FAIL idle_counters: got %0d/%0d/%0d/%0d required 0/0/0/0",
                         in_beats_pio, in_stall_pio, out_beats_pio, out_stall_pio);
    end
    checks++;
    if (status_pio !== 32'h01) begin
      errors++; $display("FAIL idle_status: got %h required 00000001", status_pio);
    end
    ctrl = 32'h0; tick();
  endtask

  task automatic test_deadlock();
    ctrl = 32'h4; tick();
    ctrl = 32'h6; tick();
    ctrl = 32'h4; hiv = 1; hir = 0;
    repeat (15) tick();
    checks++;
    if (status_pio[5:4] !== 2'd1 || deadlock_led !== 1'b0) begin
      errors++; $display("FAIL deadlock_early: state %0d led %b required state 1 led 0", status_pio[5:4], deadlock_led);
    end
    tick();
    checks++;
    if (status_pio[5:4] !== 2'd2 || deadlock_led !== 1'b1 || status_pio[1] !== 1'b1) begin
      errors++; $display("FAIL deadlock_assert: state %0d led %b flag %b required 2/1/1",
                         status_pio[5:4], deadlock_led, status_pio[1]);
    end
    hiv = 0; tick();
    checks++;
    if (status_pio[5:4] !== 2'd1 || deadlock_led !== 1'b1) begin
      errors++; $display("FAIL deadlock_sticky: state %0d led %b required 1/1", status_pio[5:4], deadlock_led);
    end
    ctrl = 32'h6; tick();
    checks++;
    if (status_pio[1] !== 1'b0 || deadlock_led !== 1'b0) begin
      errors++; $display("FAIL deadlock_clear: flag %b led %b required 0/0", status_pio[1], deadlock_led);
    end
    ctrl = 32'h4; tick();
    for (int k = 0; k < 31; k++) begin
      hiv = (k != 15); hir = 0;
      tick();
      checks++;
      if (status_pio[5:4] !== 2'd1 || deadlock_led !== 1'b0) begin
        errors++; $display("FAIL deadlock_near_miss: cycle %0d state %0d led %b required 1/0",
                           k, status_pio[5:4], deadlock_led);
      end
    end
    hiv = 0; tick();
  endtask

  task automatic test_saturation();
    ctrl = 32'h6; tick();
    ctrl = 32'h4; hiv = 1; hir = 1;
    repeat (20) tick();
    hiv = 0; ctrl = 32'h5; tick();
    checks++;
    if (in_beats_pio !== 32'd15) begin
      errors++; $display("FAIL sat_value: got %0d required 15", in_beats_pio);
    end
    checks++;
    if (status_pio !== 32'h15) begin
      errors++; $display("FAIL sat_status: got %h required 00000015", status_pio);
    end
    ctrl = 32'h4; tick();
  endtask

  task automatic test_snap_clear();
    ctrl = 32'h6; tick();
    ctrl = 32'h4; hiv = 1; hir = 1;
    repeat (5) tick();
    ctrl = 32'h7; tick();
    checks++;
    if (in_beats_pio !== 32'd5 || status_pio[0] !== 1'b1) begin
      errors++; $display("FAIL snapclr_first: got %0d valid %b required 5 valid 1", in_beats_pio, status_pio[0]);
    end
    ctrl = 32'h4; repeat (2) tick();
    hiv = 0; ctrl = 32'h5; tick();
    checks++;
    if (in_beats_pio !== 32'd2 || status_pio !== 32'h11) begin
      errors++; $display("FAIL snapclr_second: got %0d status %h required 2 status 00000011", in_beats_pio, status_pio);
    end
    ctrl = 32'h4; tick();
  endtask

  task automatic test_reset_edge();
    ctrl = 32'h4; hiv = 1; hir = 1;
    repeat (3) tick();
    rst = 1'b0; ctrl = 32'h7;
    repeat (2) tick();
    checks++;
    if ({in_beats_pio, in_stall_pio, out_beats_pio, out_stall_pio, status_pio, deadlock_led} !== 161'd0) begin
      errors++; $display("FAIL rst_mid: got %h %h %h %h %h %b required all 0",
                         in_beats_pio, in_stall_pio, out_beats_pio, out_stall_pio, status_pio, deadlock_led);
    end
    rst = 1'b1; tick();
    checks++;
    if (status_pio !== 32'h10 || in_beats_pio !== 32'd0) begin
      errors++; $display("FAIL rst_release: status %h beats %0d required 00000010 / 0", status_pio, in_beats_pio);
    end
    tick();
    checks++;
    if (status_pio !== 32'h10) begin
      errors++; $display("FAIL rst_no_spurious: status %h required 00000010", status_pio);
    end
    hiv = 0; ctrl = 32'h4; tick();
  endtask

  task automatic test_random();
    logic [159:0] act, exp;
    bit en_b, snap_b, clr_b;
    int mode;
    en_b = 1; snap_b = 0; clr_b = 0; mode = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 40 == 0) mode = $urandom_range(0, 2);
      rst = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 59) == 0) en_b  = !en_b;
      if ($urandom_range(0, 5)  == 0) snap_b = !snap_b;
      if ($urandom_range(0, 29) == 0) clr_b  = !clr_b;
      ctrl = {29'd0, en_b, clr_b, snap_b} | (32'($urandom) & 32'hFFFF_FFF8);
      if (mode == 2) begin
        hiv = 1; hir = ($urandom_range(0, 39) == 0);
      end else begin
        hiv = 1'($urandom); hir = 1'($urandom);
      end
      sov = 1'($urandom); sor = 1'($urandom);
      tick();
      act = {in_beats_pio, in_stall_pio, out_beats_pio, out_stall_pio, status_pio};
      exp = {32'(m_snap[0]), 32'(m_snap[1]), 32'(m_snap[2]), 32'(m_snap[3]), m_status()};
      checks++;
      if (act !== exp || deadlock_led !== 1'(m_dl)) begin
        errors++; $display("FAIL random_cycle %0d: got %h led %b required %h led %0d", c, act, deadlock_led, exp, m_dl);
      end
    end
    rst = 1'b1;
  endtask

  initial begin
    m_prev = 2'b00;
    test_reset();
    test_counting();
    test_idle_hold();
    test_deadlock();
    test_saturation();
    test_snap_clear();
    test_reset_edge();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
